// File: rtl/imm_extend_pipe.sv
// RV32I immediate-generation stage: classifies the instruction format, builds the
// sign-extended immediate and pc+imm target, and holds results in an output + skid register pair.
module imm_extend_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_J   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_R   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [2:0]      fmt_c;
    logic [31:0]     imm32_c;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] target_c;
    logic            accept_c;
    logic            consume_c;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic [2:0]      out_fmt_q, out_fmt_d;
    logic            out_illegal_q, out_illegal_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [XLEN-1:0] skid_target_q, skid_target_d;
    logic [2:0]      skid_fmt_q, skid_fmt_d;
    logic            skid_illegal_q, skid_illegal_d;
    logic            in_ready_q, in_ready_d;

    // Format resolution and immediate/target computation ahead of capture
    always_comb begin
        fmt_c = FMT_ILL;
        if (AUTO_DECODE) begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_c = FMT_I;
                7'b0100011:                                     fmt_c = FMT_S;
                7'b1100011:                                     fmt_c = FMT_B;
                7'b1101111:                                     fmt_c = FMT_J;
                7'b0110111, 7'b0010111:                         fmt_c = FMT_U;
                7'b0110011:                                     fmt_c = FMT_R;
                default:                                        fmt_c = FMT_ILL;
            endcase
        end else begin
            fmt_c = (imm_sel <= FMT_R) ? imm_sel : FMT_ILL;
        end

        case (fmt_c)
            FMT_I:   imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_J:   imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            FMT_U:   imm32_c = {in_instr[31:12], 12'b0};
            default: imm32_c = 32'd0;
        endcase

        imm_c    = XLEN'($signed(imm32_c));
        target_c = in_pc + imm_c;
    end

    // Occupancy control: EMPTY / ONE / FULL encoded by the two valid bits
    always_comb begin
        accept_c       = in_valid && in_ready_q;
        consume_c      = out_valid_q && out_ready;
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_target_d   = out_target_q;
        out_fmt_d      = out_fmt_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_target_d  = skid_target_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            out_valid_d    = 1'b0;
            out_imm_d      = '0;
            out_target_d   = '0;
            out_fmt_d      = 3'd0;
            out_illegal_d  = 1'b0;
            skid_valid_d   = 1'b0;
            skid_imm_d     = '0;
            skid_target_d  = '0;
            skid_fmt_d     = 3'd0;
            skid_illegal_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume_c) begin
                out_imm_d     = skid_imm_q;
                out_target_d  = skid_target_q;
                out_fmt_d     = skid_fmt_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = 1'b0;
            end
        end else if (out_valid_q) begin
            if (accept_c && consume_c) begin
                out_imm_d     = imm_c;
                out_target_d  = target_c;
                out_fmt_d     = fmt_c;
                out_illegal_d = (fmt_c == FMT_ILL);
            end else if (accept_c) begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = imm_c;
                skid_target_d  = target_c;
                skid_fmt_d     = fmt_c;
                skid_illegal_d = (fmt_c == FMT_ILL);
            end else if (consume_c) begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            out_valid_d   = 1'b1;
            out_imm_d     = imm_c;
            out_target_d  = target_c;
            out_fmt_d     = fmt_c;
            out_illegal_d = (fmt_c == FMT_ILL);
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_target_q   <= '0;
            out_fmt_q      <= 3'd0;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_target_q  <= '0;
            skid_fmt_q     <= 3'd0;
            skid_illegal_q <= 1'b0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_target_q   <= out_target_d;
            out_fmt_q      <= out_fmt_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_target_q  <= skid_target_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            in_ready_q     <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_target  = out_target_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three configurations share one stimulus stream and are checked
// against a queue-based reference model plus hand-computed literal expectations.
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc64;
    logic [2:0]  imm_sel;

    logic        a_rdy, a_vld, a_ill;
    logic [31:0] a_imm, a_tgt;
    logic [2:0]  a_fmt;
    logic        s_rdy, s_vld, s_ill;
    logic [31:0] s_imm, s_tgt;
    logic [2:0]  s_fmt;
    logic        w_rdy, w_vld, w_ill;
    logic [63:0] w_imm, w_tgt;
    logic [2:0]  w_fmt;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u_a32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc64[31:0]), .imm_sel(imm_sel), .out_valid(a_vld),
        .out_ready(out_ready), .out_imm(a_imm), .out_target(a_tgt), .out_fmt(a_fmt),
        .out_illegal(a_ill));
    imm_extend_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) u_s32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_rdy),
        .in_instr(in_instr), .in_pc(in_pc64[31:0]), .imm_sel(imm_sel), .out_valid(s_vld),
        .out_ready(out_ready), .out_imm(s_imm), .out_target(s_tgt), .out_fmt(s_fmt),
        .out_illegal(s_ill));
    imm_extend_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_a64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_rdy),
        .in_instr(in_instr), .in_pc(in_pc64), .imm_sel(imm_sel), .out_valid(w_vld),
        .out_ready(out_ready), .out_imm(w_imm), .out_target(w_tgt), .out_fmt(w_fmt),
        .out_illegal(w_ill));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  sel;
    } entry_t;

    entry_t q[$];
    bit     after_rst;
    int     n_vec  = 0;
    int     n_fail = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] fmt_of_opcode(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd0;
            7'h23:                      return 3'd1;
            7'h63:                      return 3'd2;
            7'h6F:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h33:                      return 3'd5;
            default:                    return 3'd7;
        endcase
    endfunction

    // Immediate as a 64-bit two's-complement value built from field weights
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f);
        logic [63:0] v;
        v = 64'd0;
        case (f)
            3'd0: begin v = 64'(i[31:20]); if (i[31]) v = v - 64'd4096; end
            3'd1: begin v = 64'(i[31:25]) * 64'd32 + 64'(i[11:7]); if (i[31]) v = v - 64'd4096; end
            3'd2: begin
                v = 64'(i[7]) * 64'd2048 + 64'(i[30:25]) * 64'd32 + 64'(i[11:8]) * 64'd2;
                if (i[31]) v = v - 64'd4096;
            end
            3'd3: begin
                v = 64'(i[19:12]) * 64'd4096 + 64'(i[20]) * 64'd2048 + 64'(i[30:21]) * 64'd2;
                if (i[31]) v = v - 64'd1048576;
            end
            3'd4: begin v = 64'(i[30:12]) * 64'd4096; if (i[31]) v = v - 64'd2147483648; end
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    task automatic check_dut(input string nm, input bit wide, input bit auto_dec,
                             input logic vld, input logic rdy, input logic [63:0] imm,
                             input logic [63:0] tgt, input logic [2:0] fmt, input logic ill);
        logic [63:0] mask, e_imm, e_tgt;
        logic [2:0]  e_fmt;
        mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        cmp({nm, " in_ready"}, 64'(rdy), 64'(q.size() < 2));
        cmp({nm, " out_valid"}, 64'(vld), 64'(q.size() > 0));
        if (q.size() > 0) begin
            e_fmt = auto_dec ? fmt_of_opcode(q[0].instr[6:0])
                             : ((q[0].sel <= 3'd5) ? q[0].sel : 3'd7);
            e_imm = ref_imm(q[0].instr, e_fmt) & mask;
            e_tgt = (q[0].pc + e_imm) & mask;
            cmp({nm, " out_imm"}, imm, e_imm);
            cmp({nm, " out_target"}, tgt, e_tgt);
            cmp({nm, " out_fmt"}, 64'(fmt), 64'(e_fmt));
            cmp({nm, " out_illegal"}, 64'(ill), 64'(e_fmt == 3'd7));
        end else if (after_rst) begin
            cmp({nm, " rst imm"}, imm, 64'd0);
            cmp({nm, " rst target"}, tgt, 64'd0);
            cmp({nm, " rst fmt"}, 64'(fmt), 64'd0);
            cmp({nm, " rst illegal"}, 64'(ill), 64'd0);
        end
    endtask

    task automatic check_all();
        check_dut("a32", 1'b0, 1'b1, a_vld, a_rdy, 64'(a_imm), 64'(a_tgt), a_fmt, a_ill);
        check_dut("s32", 1'b0, 1'b0, s_vld, s_rdy, 64'(s_imm), 64'(s_tgt), s_fmt, s_ill);
        check_dut("a64", 1'b1, 1'b1, w_vld, w_rdy, w_imm, w_tgt, w_fmt, w_ill);
    endtask

    // Reference behaviour: an in-order queue of at most two entries
    task automatic model_update();
        bit acc, con;
        entry_t e;
        if (reset) begin
            q.delete();
            after_rst = 1'b1;
        end else if (flush) begin
            q.delete();
            after_rst = 1'b0;
        end else begin
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            if (con) void'(q.pop_front());
            if (acc) begin
                e.instr = in_instr;
                e.pc    = in_pc64;
                e.sel   = imm_sel;
                q.push_back(e);
            end
            if (acc) after_rst = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic [2:0] sel, input logic ordy, input logic fl, input logic rs);
        in_valid  = v;
        in_instr  = ins;
        in_pc64   = pc;
        imm_sel   = sel;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17,
                             7'h33, 7'h7F};

    initial begin
        logic [31:0] r, ins;
        after_rst = 1'b0;
        in_valid = 0; in_instr = 0; in_pc64 = 0; imm_sel = 0;
        out_ready = 0; flush = 0; reset = 1;

        step(0, 32'h0, 64'h0, 3'd0, 0, 0, 1);
        cmp("lit reset in_ready", 64'(a_rdy), 64'd1);

        step(1, 32'hFFA00093, 64'h100, 3'd0, 0, 0, 0);
        cmp("lit addi imm", 64'(a_imm), 64'hFFFFFFFA);
        cmp("lit addi target", 64'(a_tgt), 64'hFA);
        cmp("lit addi fmt", 64'(a_fmt), 64'd0);
        step(1, 32'hFE20AD23, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit sw imm", 64'(a_imm), 64'hFFFFFFFA);
        cmp("lit sw fmt", 64'(a_fmt), 64'd1);
        step(1, 32'hFE208EE3, 64'h40, 3'd0, 1, 0, 0);
        cmp("lit beq imm", 64'(a_imm), 64'hFFFFFFFC);
        cmp("lit beq target", 64'(a_tgt), 64'h3C);
        step(1, 32'hFF9FF4EF, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit jal imm", 64'(a_imm), 64'hFFFFFFF8);
        cmp("lit jal fmt", 64'(a_fmt), 64'd3);
        step(1, 32'h123450B7, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit lui imm", 64'(a_imm), 64'h12345000);
        cmp("lit lui fmt", 64'(a_fmt), 64'd4);
        step(1, 32'h0000007F, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit ill imm", 64'(a_imm), 64'd0);
        cmp("lit ill fmt", 64'(a_fmt), 64'd7);
        cmp("lit ill flag", 64'(a_ill), 64'd1);
        step(1, 32'h800000B7, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit lui64 imm", w_imm, 64'hFFFFFFFF80000000);
        step(1, 32'h00600093, 64'h0, 3'd1, 1, 0, 0);
        cmp("lit sel S imm", 64'(s_imm), 64'h1);
        step(1, 32'h00600093, 64'h0, 3'd6, 1, 0, 0);
        cmp("lit sel6 illegal", 64'(s_ill), 64'd1);
        cmp("lit sel6 imm", 64'(s_imm), 64'd0);
        step(0, 32'h0, 64'h0, 3'd0, 1, 0, 0);

        // Backpressure: two accepted, third waits until the skid drains
        step(1, 32'h00100093, 64'h0, 3'd0, 0, 0, 0);
        step(1, 32'h00200093, 64'h0, 3'd0, 0, 0, 0);
        cmp("lit bp in_ready low", 64'(a_rdy), 64'd0);
        step(1, 32'h00300093, 64'h0, 3'd0, 0, 0, 0);
        cmp("lit bp hold imm", 64'(a_imm), 64'd1);
        step(1, 32'h00300093, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit bp drain1", 64'(a_imm), 64'd2);
        cmp("lit bp in_ready high", 64'(a_rdy), 64'd1);
        step(1, 32'h00300093, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit bp third", 64'(a_imm), 64'd3);
        step(0, 32'h0, 64'h0, 3'd0, 1, 0, 0);

        // Flush while full with a simultaneous offer
        step(1, 32'h00100093, 64'h0, 3'd0, 0, 0, 0);
        step(1, 32'h00200093, 64'h0, 3'd0, 0, 0, 0);
        step(1, 32'h00300093, 64'h0, 3'd0, 1, 1, 0);
        cmp("lit flush out_valid", 64'(a_vld), 64'd0);
        cmp("lit flush in_ready", 64'(a_rdy), 64'd1);
        step(0, 32'h0, 64'h0, 3'd0, 1, 0, 0);
        cmp("lit flush dropped", 64'(a_vld), 64'd0);

        // Reset while stalled full
        step(1, 32'h00100093, 64'h0, 3'd0, 0, 0, 0);
        step(1, 32'hFE208EE3, 64'h40, 3'd0, 0, 0, 0);
        step(1, 32'h00300093, 64'h0, 3'd0, 0, 0, 1);
        cmp("lit rst target", 64'(a_tgt), 64'd0);
        cmp("lit rst valid", 64'(a_vld), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            r   = $urandom();
            ins = {r[31:7], ops[$urandom_range(0, 10)]};
            if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom());
            step(($urandom_range(0, 9) < 7), ins, {32'($urandom()), 32'($urandom())},
                 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate-generation stage for the RV32I decode path. It accepts a full 32-bit instruction word and its PC through a valid/ready handshake and classifies the format, either from the opcode or from an external select. It produces the sign-extended immediate at XLEN bits, plus the branch/jump target `pc + imm`. It sits between fetch and decode/execute. It covers all immediate formats, including U, and adds a 2-entry skid buffer so upstream never sees combinational backpressure.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; immediate sign-extended to XLEN.
- `AUTO_DECODE`, 1: 1 = format derived from opcode `instr[6:0]`; 0 = format taken from `imm_sel`.
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous pipeline flush; drops all held entries.
- `in_valid`  input  1  input entry valid.
- `in_ready`  output  1  stage can accept; registered (equals NOT skid-entry-valid).
- `in_instr`  input  32  instruction word.
- `in_pc`  input  XLEN  instruction address.
- `imm_sel`  input  3  format select when AUTO_DECODE=0: 0 I, 1 S, 2 B, 3 J, 4 U, 5 R; 6–7 illegal. Ignored when AUTO_DECODE=1.
- `out_valid`  output  1  output entry valid.
- `out_ready`  input  1  downstream accepts.
- `out_imm`  output  XLEN  sign-extended immediate.
- `out_target`  output  XLEN  `in_pc + imm`, modulo 2^XLEN.
- `out_fmt`  output  3  resolved format code; 7 = illegal.
- `out_illegal`  output  1  unrecognised opcode or select.

## Operation
- Auto-decode opcode map:
  - I: 0010011, 0000011, 1100111, 1110011
  - S: 0100011
  - B: 1100011
  - J: 1101111
  - U: 0110111, 0010111
  - R: 0110011
  - Anything else: fmt 7, illegal 1.
- Immediate construction; all sign bits come from `instr[31]`:
  - I: `instr[31:20]`
  - S: `{instr[31:25], instr[11:7]}`
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`
  - U: `{instr[31:12], 12'b0}`, sign-extended above bit 31 when XLEN=64.
  - R and illegal: imm 0.
- `out_illegal` = 1 only for fmt 7; R-type is legal with imm 0.
- `out_target` is computed for every format. Overflow wraps silently.
- Storage: one output register plus one skid register; computation is done before capture.
- Input accepted when `in_valid && in_ready`; output consumed when `out_valid && out_ready`.
- Occupancy states: EMPTY (out invalid), ONE (out valid, skid empty), FULL (out valid, skid valid).
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + consume → ONE, new entry loaded into output.
  - ONE + accept, no consume → FULL, entry goes to skid.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE, skid moves to output.
  - FULL: no accept possible, since `in_ready` = 0.
- Entries never reorder, duplicate or drop, except on flush or reset.

## Timing
- Reset (sync, asserted at edge) clears all state:
  - `out_valid`, `out_imm`, `out_target`, `out_fmt`, `out_illegal` all 0.
  - Skid invalid; `in_ready` = 1 from the first cycle after reset.
  - Inputs presented in a reset cycle are discarded.
- Latency is 1 cycle: accept at edge N gives `out_valid` with the result after edge N.
- Throughput is 1 entry/cycle while `out_ready` = 1.
- `in_ready` is a flop output with no combinational path from `out_ready`. It falls the cycle after the skid fills and rises the cycle after the skid drains.
- Output fields are stable while `out_valid && !out_ready`.
- Flush clears output and skid at the edge; `in_ready` = 1 the next cycle.
  - Flush beats a simultaneous accept (the input is dropped) and a simultaneous consume.
- Reset has priority over flush.
- Reset mid-stall (FULL) discards both entries.

## Test plan
- XLEN=32, AUTO: addi -6 (0xFFA00093), pc 0x100 → after 1 cycle out_imm 0xFFFFFFFA, fmt 0, target 0x000000FA.
- Back-to-back with out_ready=1:
  - sw -6 (0xFE20AD23) → 0xFFFFFFFA, fmt 1.
  - beq -4 (0xFE208EE3), pc 0x40 → 0xFFFFFFFC, target 0x3C.
  - jal -8 (0xFF9FF4EF) → 0xFFFFFFF8, fmt 3.
  - One result per cycle, in order.
- U and illegal:
  - lui 0x12345 (0x123450B7) → 0x12345000, fmt 4.
  - Opcode 0x7F → imm 0, fmt 7, illegal 1.
  - XLEN=64: lui 0x80000 → 0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0, offer 3 entries → 2 accepted, in_ready=0 from the cycle after the 2nd. Raising out_ready drains both in order, then the 3rd is accepted.
- Flush in the FULL state with in_valid=1 the same cycle → next cycle out_valid=0, in_ready=1, and the input is not captured.
- AUTO_DECODE=0: instr 0x00600093 with imm_sel=1 → S-format imm 0x00000001. imm_sel=6 → illegal 1, imm 0. Reset asserted mid-stream → all outputs 0 the next cycle.
